// File: rtl/myrecvfromfx2lp_if.sv
// Port bundle for the FX2LP OUT-endpoint receiver: slave-FIFO pins, Avalon-ST source and status.
// master = receiver side, slave = the FX2LP/sink environment driving the other end.
interface myrecvfromfx2lp_if;
    localparam int unsigned FD_W   = 8;
    localparam int unsigned FLAG_W = 3;
    localparam int unsigned ADR_W  = 2;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 2;

    logic                enable;
    logic [FD_W-1:0]     fx2lp_fd;
    logic [FLAG_W-1:0]   fx2lp_flag_n;
    logic                fx2lp_slrd_n;
    logic                fx2lp_sloe_n;
    logic [ADR_W-1:0]    fx2lp_fifoadr;
    logic [WORD_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;
    logic [CNT_W-1:0]    byte_cnt;
    logic [WORD_W-1:0]   rx_bytes;

    modport master (
        input  enable, fx2lp_fd, fx2lp_flag_n, out_ready,
        output fx2lp_slrd_n, fx2lp_sloe_n, fx2lp_fifoadr,
               out_data, out_valid, byte_cnt, rx_bytes
    );

    modport slave (
        output enable, fx2lp_fd, fx2lp_flag_n, out_ready,
        input  fx2lp_slrd_n, fx2lp_sloe_n, fx2lp_fifoadr,
               out_data, out_valid, byte_cnt, rx_bytes
    );
endinterface

// File: rtl/myrecvfromfx2lp.sv
// Reads bytes from an FX2LP OUT endpoint (synchronous slave FIFO) and packs them
// little-endian into 32-bit words on an Avalon-ST source.
module myrecvfromfx2lp #(
    parameter logic [1:0]  EP_ADDR   = 2'b00,
    parameter int unsigned EMPTY_IDX = 0
) (
    input  logic              clk,
    input  logic              reset,
    myrecvfromfx2lp_if.master bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned SHR_W  = 24;
    localparam logic [1:0]  EMPTY_SEL = 2'(EMPTY_IDX);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OE    = 3'd1,
        S_CHECK = 3'd2,
        S_READ  = 3'd3,
        S_WAIT  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              sloe_n_q, sloe_n_d;
    logic              slrd_n_q, slrd_n_d;
    logic              empty_q;
    logic [SHR_W-1:0]  shift_q;
    logic [WORD_W-1:0] data_q;
    logic              valid_q;
    logic [1:0]        cnt_q;
    logic [WORD_W-1:0] rx_q;
    logic              stall_c;

    // A fourth byte cannot be accepted while the previous word is still unaccepted.
    assign stall_c = (cnt_q == 2'd3) && valid_q;

    // State, strobes and the registered empty flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sloe_n_q <= 1'b1;
            slrd_n_q <= 1'b1;
            empty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            sloe_n_q <= sloe_n_d;
            slrd_n_q <= slrd_n_d;
            empty_q  <= ~bus.fx2lp_flag_n[EMPTY_SEL];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.enable) state_d = S_OE;
            S_OE:    state_d = S_CHECK;
            S_CHECK: begin
                if (!bus.enable)              state_d = S_IDLE;
                else if (!empty_q && !stall_c) state_d = S_READ;
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT:  state_d = S_CHECK;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they are registered alongside it.
    always_comb begin
        sloe_n_d = 1'b0;
        slrd_n_d = 1'b1;
        case (state_d)
            S_IDLE:  sloe_n_d = 1'b1;
            S_READ:  slrd_n_d = 1'b0;
            default: ;
        endcase
    end

    // Byte capture and word assembly; a load overrides a same-edge accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= 2'd0;
            rx_q    <= '0;
        end else begin
            if (valid_q && bus.out_ready) valid_q <= 1'b0;
            if (state_q == S_READ) begin
                cnt_q <= cnt_q + 2'd1;
                rx_q  <= rx_q + 32'd1;
                case (cnt_q)
                    2'd0:    shift_q[7:0]   <= bus.fx2lp_fd;
                    2'd1:    shift_q[15:8]  <= bus.fx2lp_fd;
                    2'd2:    shift_q[23:16] <= bus.fx2lp_fd;
                    default: begin
                        data_q  <= {bus.fx2lp_fd, shift_q};
                        valid_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.fx2lp_sloe_n  = sloe_n_q;
    assign bus.fx2lp_slrd_n  = slrd_n_q;
    assign bus.fx2lp_fifoadr = EP_ADDR;
    assign bus.out_data      = data_q;
    assign bus.out_valid     = valid_q;
    assign bus.byte_cnt      = cnt_q;
    assign bus.rx_bytes      = rx_q;
endmodule

// File: tb/tb_myrecvfromfx2lp.sv
// Directed bench for myrecvfromfx2lp with a small FX2LP OUT-FIFO model and word monitor.
module tb_myrecvfromfx2lp;
    logic clk = 1'b0;
    logic reset;

    myrecvfromfx2lp_if bus ();

    myrecvfromfx2lp #(.EP_ADDR(2'b00), .EMPTY_IDX(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // FX2LP FIFO model: pops the byte half a cycle after the read edge.
    logic [7:0]  fifo_mem [0:63];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    logic        pend   = 1'b0;
    int unsigned cyc    = 0;
    logic [31:0] words [$];
    int unsigned strobes [$];

    assign bus.fx2lp_fd     = fifo_mem[rd_ptr[5:0]];
    assign bus.fx2lp_flag_n = {2'b11, rd_ptr != wr_ptr};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pend && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 1;
        pend <= !reset && (bus.fx2lp_slrd_n == 1'b0);
        if (bus.fx2lp_slrd_n == 1'b0) strobes.push_back(cyc);
        if (bus.out_valid && bus.out_ready) words.push_back(bus.out_data);
    end

    typedef struct {
        int          nbytes;
        logic [63:0] data;
        int          nwords;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [1:0]  cnt;
    } vec_t;

    vec_t vecs [5];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int idx);
        if (idx < words.size()) return words[idx];
        return 32'hDEAD_0BAD;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        fifo_mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        bus.enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        wr_ptr = rd_ptr;
        reset  = 1'b0;
    endtask

    task automatic wait_read(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.fx2lp_slrd_n == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  wbase, sbase, c0, bad, nrd;
        bit  ok;

        vecs[0] = '{8, 64'h8877_6655_4433_2211, 2, 32'h4433_2211, 32'h8877_6655, 2'd0};
        vecs[1] = '{5, 64'h0000_00A5_A4A3_A2A1, 1, 32'hA4A3_A2A1, 32'h0, 2'd1};
        vecs[2] = '{4, 64'h0000_0000_EFBE_ADDE, 1, 32'hEFBE_ADDE, 32'h0, 2'd0};
        vecs[3] = '{0, 64'h0,                   0, 32'h0,        32'h0, 2'd0};
        vecs[4] = '{6, 64'h0000_0605_0403_0201, 1, 32'h0403_0201, 32'h0, 2'd2};

        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        check("rst_slrd_n",  32'(bus.fx2lp_slrd_n), 32'd1);
        check("rst_sloe_n",  32'(bus.fx2lp_sloe_n), 32'd1);
        check("rst_valid",   32'(bus.out_valid), 32'd0);
        check("rst_data",    bus.out_data, 32'd0);
        check("rst_cnt",     32'(bus.byte_cnt), 32'd0);
        check("rst_rx",      bus.rx_bytes, 32'd0);
        check("rst_fifoadr", 32'(bus.fx2lp_fifoadr), 32'd0);

        // Empty FIFO: output enable asserted, no read strobe
        wr_ptr = rd_ptr;
        reset  = 1'b0;
        sbase  = strobes.size();
        bus.enable = 1'b1;
        repeat (2) @(posedge clk);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.fx2lp_sloe_n !== 1'b0) bad++;
        end
        check("empty_sloe_low", 32'(bad), 32'd0);
        check("empty_no_strobe", 32'(strobes.size() - sbase), 32'd0);
        check("empty_valid", 32'(bus.out_valid), 32'd0);

        // Table: transfers with out_ready held high
        for (int v = 0; v < 5; v++) begin
            do_reset();
            check($sformatf("v%0d_idle_sloe", v), 32'(bus.fx2lp_sloe_n), 32'd1);
            bus.out_ready = 1'b1;
            for (int i = 0; i < vecs[v].nbytes; i++) push_byte(vecs[v].data[8*i +: 8]);
            wbase = words.size();
            sbase = strobes.size();
            c0    = int'(cyc);
            bus.enable = 1'b1;
            repeat (40) @(posedge clk);
            #1;
            check($sformatf("v%0d_nwords", v), 32'(words.size() - wbase), 32'(vecs[v].nwords));
            if (vecs[v].nwords >= 1) check($sformatf("v%0d_w0", v), word_at(wbase), vecs[v].w0);
            if (vecs[v].nwords >= 2) check($sformatf("v%0d_w1", v), word_at(wbase + 1), vecs[v].w1);
            check($sformatf("v%0d_cnt", v), 32'(bus.byte_cnt), 32'(vecs[v].cnt));
            check($sformatf("v%0d_rx", v), bus.rx_bytes, 32'(vecs[v].nbytes));
            check($sformatf("v%0d_valid", v), 32'(bus.out_valid), 32'd0);
            check($sformatf("v%0d_nstrobe", v), 32'(strobes.size() - sbase), 32'(vecs[v].nbytes));
            if (strobes.size() > sbase)
                check($sformatf("v%0d_first_rd", v), 32'(int'(strobes[sbase]) - c0), 32'd3);
            for (int k = sbase + 1; k < strobes.size(); k++)
                check($sformatf("v%0d_spacing%0d", v, k - sbase), 32'(strobes[k] - strobes[k-1]), 32'd3);
            bus.enable = 1'b0;
        end

        // Stall: sink not ready holds the 4th byte of the second word
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_byte(8'(i * 17));
        wbase = words.size();
        sbase = strobes.size();
        bus.enable = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("stall_cnt",    32'(bus.byte_cnt), 32'd3);
        check("stall_valid",  32'(bus.out_valid), 32'd1);
        check("stall_data",   bus.out_data, 32'h4433_2211);
        check("stall_rx",     bus.rx_bytes, 32'd7);
        check("stall_slrd_n", 32'(bus.fx2lp_slrd_n), 32'd1);
        check("stall_nstrobe", 32'(strobes.size() - sbase), 32'd7);
        sbase = strobes.size();
        bus.out_ready = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("unstall_nstrobe", 32'(strobes.size() - sbase), 32'd1);
        check("unstall_nwords", 32'(words.size() - wbase), 32'd2);
        check("unstall_w0",     word_at(wbase), 32'h4433_2211);
        check("unstall_w1",     word_at(wbase + 1), 32'h8877_6655);
        check("unstall_data",   bus.out_data, 32'h8877_6655);
        check("unstall_rx",     bus.rx_bytes, 32'd8);

        // Partial word held while the FIFO runs dry, completed later
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) push_byte(8'(i * 17));
        wbase = words.size();
        bus.enable = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("part_cnt", 32'(bus.byte_cnt), 32'd1);
        check("part_nwords", 32'(words.size() - wbase), 32'd1);
        check("part_w0", word_at(wbase), 32'h4433_2211);
        push_byte(8'h66);
        push_byte(8'h77);
        push_byte(8'h88);
        repeat (20) @(posedge clk);
        #1;
        check("resume_nwords", 32'(words.size() - wbase), 32'd2);
        check("resume_w1", word_at(wbase + 1), 32'h8877_6655);
        check("resume_cnt", 32'(bus.byte_cnt), 32'd0);
        check("resume_rx", bus.rx_bytes, 32'd8);

        // enable dropped during READ: byte captured, then back to IDLE
        do_reset();
        bus.out_ready = 1'b1;
        push_byte(8'hAA);
        push_byte(8'hBB);
        bus.enable = 1'b1;
        wait_read(ok);
        check("endrop_read_seen", 32'(ok), 32'd1);
        bus.enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("endrop_sloe_n", 32'(bus.fx2lp_sloe_n), 32'd1);
        check("endrop_cnt", 32'(bus.byte_cnt), 32'd1);
        check("endrop_rx", bus.rx_bytes, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("endrop_idle_rx", bus.rx_bytes, 32'd1);
        bus.enable = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("reen_cnt", 32'(bus.byte_cnt), 32'd2);
        check("reen_rx", bus.rx_bytes, 32'd2);
        bus.enable = 1'b0;

        // Reset asserted mid-READ of the 6th byte
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push_byte(8'(i));
        bus.enable = 1'b1;
        nrd = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.fx2lp_slrd_n == 1'b0) nrd++;
            if (nrd == 6) break;
        end
        check("rstrd_reached", 32'(nrd), 32'd6);
        check("rstrd_pre_cnt", 32'(bus.byte_cnt), 32'd1);
        check("rstrd_pre_valid", 32'(bus.out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rstrd_slrd_n", 32'(bus.fx2lp_slrd_n), 32'd1);
        check("rstrd_sloe_n", 32'(bus.fx2lp_sloe_n), 32'd1);
        check("rstrd_cnt", 32'(bus.byte_cnt), 32'd0);
        check("rstrd_rx", bus.rx_bytes, 32'd0);
        check("rstrd_valid", 32'(bus.out_valid), 32'd0);
        check("rstrd_data", bus.out_data, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
